// File: rtl/mux_rr_pkg.sv
// mux_rr_pkg: shared defaults and helpers for the round-robin stream mux.
//   DEFAULT_W / DEFAULT_N_CH : default data width and channel count
//   idx_w(n)                 : channel-index width, $clog2(n) but never below 1
//   next_ptr(idx, n)         : channel after idx, wrapping at n-1 (not at 2^k-1)
package mux_rr_pkg;

    localparam int unsigned DEFAULT_W    = 8;
    localparam int unsigned DEFAULT_N_CH = 4;

    // A single channel still needs a 1-bit index to keep port widths legal.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Wrap on the real channel count so non-power-of-2 N_CH never points at a ghost channel.
    function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     : per-channel request
//   ptr     : highest-priority channel this cycle
//   en      : grant enable; when low gnt is all zero
//   gnt     : one-hot grant (zero when no request or en low)
//   gnt_idx : index of the first requester at or after ptr (meaningful only when some req)
module rr_arbiter
    import mux_rr_pkg::*;
#(
    parameter  int unsigned N_CH  = DEFAULT_N_CH,
    localparam int unsigned IDX_W = idx_w(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N_CH-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic found;

    // Two passes: channels ptr..N_CH-1 first, then the wrapped tail 0..ptr-1.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && req[i] && (i >= 32'(ptr))) begin
                gnt[i]  = en;
                gnt_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!found && req[i] && (i < 32'(ptr))) begin
                gnt[i]  = en;
                gnt_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arb.sv
// mux_rr_arb: merges N_CH valid/ready streams onto one registered output,
// round-robin over requesting channels, one word per cycle at full rate.
//   clk, resetN          : clock, synchronous active-low reset
//   in_valid/in_data     : per-channel request and packed data (channel i at [i*W +: W])
//   in_ready             : per-channel accept (combinational, at most one bit high)
//   out_valid/out_data   : output register
//   out_ready            : consumer accept
//   out_sel              : source channel of out_data, present only when
//                          MUX_RR_SEL_OUT_EN is defined
module mux_rr_arb
    import mux_rr_pkg::*;
#(
    parameter  int unsigned N_CH  = DEFAULT_N_CH,
    parameter  int unsigned W     = DEFAULT_W,
    localparam int unsigned IDX_W = idx_w(N_CH)
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    input  logic              out_ready
`ifdef MUX_RR_SEL_OUT_EN
    ,
    output logic [IDX_W-1:0]  out_sel
`endif
);

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    logic [IDX_W-1:0] ptr_q,       ptr_d;
`ifdef MUX_RR_SEL_OUT_EN
    logic [IDX_W-1:0] sel_q,       sel_d;
`endif

    logic             load_en;
    logic [N_CH-1:0]  gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             xfer;
    logic [W-1:0]     gnt_data;

    // Output slot is free when empty or being drained this cycle; held low in reset.
    assign load_en = resetN && (!out_valid_q || out_ready);

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .en      (load_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // gnt is only set on requesting channels, so any grant bit is a completed handshake.
    assign in_ready = gnt;
    assign xfer     = |gnt;

    // AND-OR select of the granted channel's word.
    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            gnt_data |= in_data[i*W +: W] & {W{gnt[i]}};
        end
    end

    // Next state of the output register and round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ptr_d       = ptr_q;
`ifdef MUX_RR_SEL_OUT_EN
        sel_d       = sel_q;
`endif
        if (load_en) begin
            if (xfer) begin
                out_valid_d = 1'b1;
                out_data_d  = gnt_data;
                ptr_d       = IDX_W'(next_ptr(32'(gnt_idx), N_CH));
`ifdef MUX_RR_SEL_OUT_EN
                sel_d       = gnt_idx;
`endif
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers, synchronous reset drops any held word.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ptr_q       <= '0;
`ifdef MUX_RR_SEL_OUT_EN
            sel_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ptr_q       <= ptr_d;
`ifdef MUX_RR_SEL_OUT_EN
            sel_q       <= sel_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef MUX_RR_SEL_OUT_EN
    assign out_sel   = sel_q;
`endif

endmodule
